// File: rtl/mips_pkg.sv
// mips_pkg: shared width, mult/div op encodings and FSM states
package mips_pkg;
  localparam int N = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit owning HI/LO with MTHI/MTLO writes
module mult_div_unit
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N) + 1;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic neg_q, neg_d, rsign_q, rsign_d, dz_q, dz_d, busy_q, busy_d, done_q, done_d;
  logic [N-1:0] mb_q, mb_d, araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sa, sb, ge;
  logic [N:0] sum;
  logic [N+1:0] trial;
  logic [2*N-1:0] prod;
  logic [N-1:0] quo, rmd;
  assign sa = ~op[0] & a[N-1];
  assign sb = ~op[0] & b[N-1];
  assign sum = acc_q[0] ? {1'b0, acc_q[2*N-1:N]} + {1'b0, mb_q} : {1'b0, acc_q[2*N-1:N]};
  assign trial = {rem_q, acc_q[N-1]};
  assign ge = trial >= {2'b00, mb_q};
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
  assign rmd = rsign_q ? -rem_q[N-1:0] : rem_q[N-1:0];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rsign_d = rsign_q;
    dz_d    = dz_q;
    mb_d    = mb_q;
    araw_d  = araw_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      op_d    = op;
      neg_d   = sa ^ sb;
      rsign_d = sa;
      dz_d    = b == '0;
      mb_d    = sb ? -b : b;
      araw_d  = a;
      acc_d   = {{N{1'b0}}, sa ? -a : a};
      rem_d   = '0;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      hi_d = mthi ? wdata : hi_q;
      lo_d = mtlo ? wdata : lo_q;
    end else if (state_q == RUN) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(N - 1) ? FIN : RUN;
      acc_d   = op_q[1] ? {acc_q[2*N-1:N], acc_q[N-2:0], ge} : {sum, acc_q[N-1:1]};
      rem_d   = op_q[1] ? (ge ? (N+1)'(trial - {2'b00, mb_q}) : trial[N:0]) : rem_q;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
      hi_d    = !op_q[1] ? prod[2*N-1:N] : dz_q ? araw_q : rmd;
      lo_d    = !op_q[1] ? prod[N-1:0] : dz_q ? {N{1'b1}} : quo;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      mb_q    <= '0;
      araw_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
      mb_q    <= mb_d;
      araw_q  <= araw_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import mips_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int nv = 0, nerr = 0;
  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nv++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    logic bad;
    bad = 1'b0;
    launch(o, x, y);
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
      tick();
    end
    chk({tag, "_busy_window"}, {31'd0, bad}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask
  initial begin
    logic bad;
    tick();
    tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_negneg", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_z", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div_z", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    launch(OP_MULTU, 32'd3, 32'd4);
    for (int c = 1; c <= 33; c++) begin
      mthi = c == 5;
      wdata = 32'hDEAD;
      start = c == 10;
      op = OP_DIVU;
      a = 32'd100;
      b = 32'd7;
      tick();
    end
    mthi = 1'b0;
    start = 1'b0;
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd12);
    tick();
    chk("ign_no_relaunch", {31'd0, busy}, 32'd0);
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mv_hi", hi, 32'h1234);
    chk("mv_lo", lo, 32'h1234);
    mtlo = 1'b1;
    wdata = 32'h5555;
    launch(OP_MULTU, 32'd6, 32'd7);
    mtlo = 1'b0;
    chk("stmv_lo_kept", lo, 32'h1234);
    chk("stmv_busy", {31'd0, busy}, 32'd1);
    repeat (33) tick();
    chk("stmv_done", {31'd0, done}, 32'd1);
    chk("stmv_hi", hi, 32'h0);
    chk("stmv_lo", lo, 32'd42);
    tick();
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    bad = 1'b0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("mrst_quiet", {31'd0, bad}, 32'd0);
    run_op("post_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
